// File: rtl/udp_share_ctrl_pkg.sv
// rtl/udp_share_ctrl_pkg.sv - shared types and helpers for the udp sharing controller
package udp_share_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Settle down-counter width; covers SETTLE up to 15.
    localparam int SCW = 4;

    function automatic int idw_f(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/udp_share_ctrl_if.sv
// rtl/udp_share_ctrl_if.sv - requester and primitive-side signal bundle
interface udp_share_ctrl_if
    import udp_share_pkg::*;
#(
    parameter int NREQ = 4
);
    localparam int IDW = idw_f(NREQ);

    logic [NREQ-1:0] req;
    logic [NREQ-1:0] a_in;
    logic [NREQ-1:0] b_in;
    logic [NREQ-1:0] gnt;
    logic            rsp_valid;
    logic [IDW-1:0]  rsp_id;
    logic            rsp_z;
    logic            udp_x;
    logic            udp_y;
    logic            udp_z;

    modport master (
        output req, a_in, b_in,
        input  gnt, rsp_valid, rsp_id, rsp_z
    );

    modport slave (
        input  req, a_in, b_in, udp_z,
        output gnt, rsp_valid, rsp_id, rsp_z, udp_x, udp_y
    );

endinterface

// File: rtl/udp_share_ctrl_rr_pick.sv
// rtl/udp_share_ctrl_rr_pick.sv - combinational round-robin pick starting at a pointer
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  idx_o,
    output logic            any_o
);

    always_comb begin
        int j;
        j     = 0;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        // Pointer is always < NREQ, so one subtraction wraps the scan index.
        for (int i = 0; i < NREQ; i++) begin
            j = int'(ptr_i) + i;
            if (j >= NREQ) j = j - NREQ;
            if (!any_o && req_i[j]) begin
                any_o    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/udp_share_ctrl.sv
// rtl/udp_share_ctrl.sv - round-robin sharing of one 2-input primitive among NREQ requesters
module udp_share_ctrl
    import udp_share_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int SETTLE = 1,
    parameter int CNTW   = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    udp_share_ctrl_if.slave bus,
    output logic            busy,
    output logic [CNTW-1:0] op_count
);

    localparam int IDW = idw_f(NREQ);

    state_t          state_q;
    logic [NREQ-1:0] gnt_q;
    logic [IDW-1:0]  ptr_q;
    logic [IDW-1:0]  id_q;
    logic [SCW-1:0]  cnt_q;
    logic            x_q, y_q, z_q, vld_q, busy_q;
    logic [CNTW-1:0] ops_q;

    logic [NREQ-1:0] win_oh;
    logic [IDW-1:0]  win_idx;
    logic            win_any;

    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .req_i (bus.req),
        .ptr_i (ptr_q),
        .gnt_o (win_oh),
        .idx_o (win_idx),
        .any_o (win_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
            id_q    <= '0;
            cnt_q   <= '0;
            x_q     <= 1'b0;
            y_q     <= 1'b0;
            z_q     <= 1'b0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            ops_q   <= '0;
        end else begin
            gnt_q <= '0;
            vld_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (win_any) begin
                        gnt_q   <= win_oh;
                        x_q     <= bus.a_in[win_idx];
                        y_q     <= bus.b_in[win_idx];
                        id_q    <= win_idx;
                        ptr_q   <= (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + IDW'(1);
                        busy_q  <= 1'b1;
                        state_q <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    if (SETTLE == 0) begin
                        z_q     <= bus.udp_z;
                        vld_q   <= 1'b1;
                        state_q <= ST_RESP;
                    end else begin
                        cnt_q   <= SCW'(SETTLE - 1);
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == '0) begin
                        z_q     <= bus.udp_z;
                        vld_q   <= 1'b1;
                        state_q <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - SCW'(1);
                    end
                end
                ST_RESP: begin
                    ops_q   <= ops_q + CNTW'(1);
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.rsp_valid = vld_q;
    assign bus.rsp_id    = id_q;
    assign bus.rsp_z     = z_q;
    assign bus.udp_x     = x_q;
    assign bus.udp_y     = y_q;
    assign busy          = busy_q;
    assign op_count      = ops_q;

endmodule

// File: tb/tb_udp_share_ctrl.sv
// tb/tb_udp_share_ctrl.sv - self-checking bench for udp_share_ctrl
module tb_udp_share_ctrl;

    typedef struct {
        logic [3:0] req;
        logic [3:0] a;
        logic [3:0] b;
        int         id;
        logic       z;
    } vec_t;

    typedef struct {
        int   id;
        logic z;
        int   cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    udp_share_ctrl_if #(.NREQ(4)) bus0 ();
    udp_share_ctrl_if #(.NREQ(3)) bus1 ();
    logic        busy0, busy1;
    logic [15:0] cnt0;
    logic [1:0]  cnt1;

    assign bus0.udp_z = bus0.udp_x & bus0.udp_y;
    assign bus1.udp_z = bus1.udp_x & bus1.udp_y;

    udp_share_ctrl #(.NREQ(4), .SETTLE(1), .CNTW(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0.slave), .busy(busy0), .op_count(cnt0)
    );

    udp_share_ctrl #(.NREQ(3), .SETTLE(0), .CNTW(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave), .busy(busy1), .op_count(cnt1)
    );

    int   nvec = 0;
    int   nerr = 0;
    int   model0 = 0;
    exp_t sb[$];
    vec_t vt[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // One full operation on dut0 (SETTLE=1): drive, see grant, see response.
    task automatic run_op0(input logic [3:0] req, input logic [3:0] a, input logic [3:0] b,
                           input int id, input logic z);
        int   t;
        int   k;
        exp_t e;
        bus0.req  = req;
        bus0.a_in = a;
        bus0.b_in = b;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (bus0.gnt == '0 && t < 8);
        chk("gnt0", 32'(bus0.gnt), 32'(1 << id));
        chk("gnt0_lat", t, 1);
        sb.push_back('{id: id, z: z, cnt: model0});
        bus0.req = '0;
        k = 0;
        while (!bus0.rsp_valid && k < 8) begin
            @(negedge clk);
            k++;
        end
        chk("rsp0_lat", k, 2);
        if (bus0.rsp_valid && sb.size() > 0) begin
            e = sb.pop_front();
            chk("rsp0_id", 32'(bus0.rsp_id), e.id);
            chk("rsp0_z", 32'(bus0.rsp_z), 32'(e.z));
            chk("rsp0_cnt", 32'(cnt0), e.cnt);
        end else begin
            chk("rsp0_seen", 0, 1);
        end
        @(negedge clk);
        model0++;
        chk("busy0_after", 32'(busy0), 0);
        chk("cnt0_after", 32'(cnt0), model0);
    endtask

    initial begin
        int   t;
        int   k;
        exp_t e;
        int   id1[5]  = '{0, 1, 2, 0, 1};
        logic z1[5]   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        int   cnt1e[5] = '{1, 2, 3, 0, 1};

        vt[0]  = '{4'b0001, 4'b0001, 4'b0001, 0, 1'b1};
        vt[1]  = '{4'b1111, 4'b0101, 4'b1111, 1, 1'b0};
        vt[2]  = '{4'b1111, 4'b0101, 4'b1111, 2, 1'b1};
        vt[3]  = '{4'b1111, 4'b0101, 4'b1111, 3, 1'b0};
        vt[4]  = '{4'b1111, 4'b0101, 4'b1111, 0, 1'b1};
        vt[5]  = '{4'b1111, 4'b0101, 4'b1111, 1, 1'b0};
        vt[6]  = '{4'b0100, 4'b0100, 4'b0000, 2, 1'b0};
        vt[7]  = '{4'b0011, 4'b0011, 4'b0001, 0, 1'b1};
        vt[8]  = '{4'b0011, 4'b0011, 4'b0001, 1, 1'b0};
        vt[9]  = '{4'b1001, 4'b1000, 4'b1000, 3, 1'b1};
        vt[10] = '{4'b1001, 4'b1000, 4'b1000, 0, 1'b0};

        bus0.req = '0; bus0.a_in = '0; bus0.b_in = '0;
        bus1.req = '0; bus1.a_in = '0; bus1.b_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_gnt", 32'(bus0.gnt), 0);
        chk("rst_vld", 32'(bus0.rsp_valid), 0);
        chk("rst_busy", 32'(busy0), 0);
        chk("rst_cnt", 32'(cnt0), 0);
        chk("rst_udpx", 32'(bus0.udp_x), 0);
        rst_n = 1'b1;

        repeat (3) begin
            @(negedge clk);
            chk("idle_busy", 32'(busy0), 0);
            chk("idle_gnt", 32'(bus0.gnt), 0);
        end

        for (int v = 0; v < 11; v++)
            run_op0(vt[v].req, vt[v].a, vt[v].b, vt[v].id, vt[v].z);

        // Abort during WAIT; pointer was 2 before reset so a restart at 0 picks 1 from 1010.
        bus0.req = 4'b0010; bus0.a_in = 4'b0010; bus0.b_in = 4'b0010;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (bus0.gnt == '0 && t < 8);
        chk("abort_gnt", 32'(bus0.gnt), 32'h2);
        bus0.req = '0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_gnt0", 32'(bus0.gnt), 0);
        chk("abort_id", 32'(bus0.rsp_id), 0);
        chk("abort_udpx", 32'(bus0.udp_x), 0);
        chk("abort_udpy", 32'(bus0.udp_y), 0);
        chk("abort_busy", 32'(busy0), 0);
        chk("abort_cnt", 32'(cnt0), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model0 = 0;
        repeat (2) begin
            @(negedge clk);
            chk("abort_novld", 32'(bus0.rsp_valid), 0);
        end
        run_op0(4'b1010, 4'b0010, 4'b0010, 1, 1'b1);

        // dut1: NREQ=3, SETTLE=0, CNTW=2, req held high throughout.
        bus1.req = 3'b111; bus1.a_in = 3'b101; bus1.b_in = 3'b111;
        for (int n = 0; n < 5; n++) begin
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (bus1.gnt == '0 && t < 8);
            chk("gnt1", 32'(bus1.gnt), 32'(1 << id1[n]));
            sb.push_back('{id: id1[n], z: z1[n], cnt: cnt1e[n]});
            k = 0;
            while (!bus1.rsp_valid && k < 8) begin
                @(negedge clk);
                k++;
            end
            chk("rsp1_lat", k, 1);
            if (bus1.rsp_valid && sb.size() > 0) begin
                e = sb.pop_front();
                chk("rsp1_id", 32'(bus1.rsp_id), e.id);
                chk("rsp1_z", 32'(bus1.rsp_z), 32'(e.z));
                @(negedge clk);
                chk("cnt1_after", 32'(cnt1), e.cnt);
            end else begin
                chk("rsp1_seen", 0, 1);
            end
        end
        bus1.req = '0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

endmodule
